// File: rtl/img_pkg.sv
// Widths and pixel type shared by the image processing path.
package img_pkg;
  localparam int DATA_W  = 12;
  localparam int COORD_W = 11;
  typedef logic [DATA_W-1:0] pix_t;
endpackage

// File: rtl/pair_line_buffer.sv
// One-row store of even-row pixel pairs; 1 write port, 1 registered read port.
// Read data lands one cycle after rd_en and is held until the next read.
module pair_line_buffer #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 24,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_dat
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_d;
  logic [WIDTH-1:0] rd_q;

  // Array contents deliberately survive reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  always_comb begin
    rd_d = rd_q;
    if (rd_en) begin
      rd_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_dat = rd_q;
endmodule

// File: rtl/bayer_quad_grey.sv
// Averages each 2x2 Bayer quad into one grey pixel at half resolution.
// Output registered 1 cycle after the odd-row/odd-column beat; no backpressure.
module bayer_quad_grey #(
  parameter int IMG_WIDTH = 1280,
  parameter int DATA_W    = img_pkg::DATA_W
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic [img_pkg::COORD_W-1:0] iX_Cont,
  input  logic [img_pkg::COORD_W-1:0] iY_Cont,
  input  logic [DATA_W-1:0]           iDATA,
  input  logic                        iDVAL,
  output logic [DATA_W-1:0]           oDATA,
  output logic [img_pkg::COORD_W-1:0] oX_Cont,
  output logic [img_pkg::COORD_W-1:0] oY_Cont,
  output logic                        oDVAL
);
  localparam int CW     = img_pkg::COORD_W;
  localparam int HALF_W = IMG_WIDTH / 2;
  localparam int ADDR_W = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int PAIR_W = 2 * DATA_W;
  localparam int SUM_W  = DATA_W + 2;
  localparam logic [CW:0] X_LIMIT = IMG_WIDTH[CW:0];

  logic              accept;
  logic              row_odd;
  logic              col_odd;
  logic              wr_en;
  logic              rd_en;
  logic              quad_done;
  logic [ADDR_W-1:0] buf_addr;
  logic [PAIR_W-1:0] wr_pair;
  logic [PAIR_W-1:0] rd_pair;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] avg;

  logic [DATA_W-1:0] hold_even_d, hold_even_q;
  logic [DATA_W-1:0] hold_odd_d,  hold_odd_q;
  logic [DATA_W-1:0] dat_d,       dat_q;
  logic [CW-1:0]     x_d,         x_q;
  logic [CW-1:0]     y_d,         y_q;
  logic              vld_d,       vld_q;

  // A beat coinciding with reset is dropped so it cannot touch the RAM either.
  assign accept   = iDVAL && !iRST && ({1'b0, iX_Cont} < X_LIMIT);
  assign row_odd  = iY_Cont[0];
  assign col_odd  = iX_Cont[0];
  assign buf_addr = iX_Cont[ADDR_W:1];

  assign wr_en     = accept && !row_odd && col_odd;
  assign rd_en     = accept && row_odd && !col_odd;
  assign quad_done = accept && row_odd && col_odd;
  assign wr_pair   = {hold_even_q, iDATA};

  pair_line_buffer #(
    .DEPTH  (HALF_W),
    .WIDTH  (PAIR_W),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk     (iCLK),
    .rst     (iRST),
    .wr_en   (wr_en),
    .wr_addr (buf_addr),
    .wr_dat  (wr_pair),
    .rd_en   (rd_en),
    .rd_addr (buf_addr),
    .rd_dat  (rd_pair)
  );

  // Four DATA_W values fit in DATA_W+2 bits, so the sum never wraps.
  assign sum = {2'b00, rd_pair[PAIR_W-1:DATA_W]} + {2'b00, rd_pair[DATA_W-1:0]}
             + {2'b00, hold_odd_q} + {2'b00, iDATA};
  assign avg = DATA_W'(sum >> 2);

  always_comb begin
    hold_even_d = hold_even_q;
    hold_odd_d  = hold_odd_q;
    dat_d       = dat_q;
    x_d         = x_q;
    y_d         = y_q;
    vld_d       = 1'b0;
    if (accept && !row_odd && !col_odd) begin
      hold_even_d = iDATA;
    end
    if (rd_en) begin
      hold_odd_d = iDATA;
    end
    if (quad_done) begin
      dat_d = avg;
      x_d   = {1'b0, iX_Cont[CW-1:1]};
      y_d   = {1'b0, iY_Cont[CW-1:1]};
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hold_even_q <= '0;
      hold_odd_q  <= '0;
      dat_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      vld_q       <= 1'b0;
    end else begin
      hold_even_q <= hold_even_d;
      hold_odd_q  <= hold_odd_d;
      dat_q       <= dat_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vld_q       <= vld_d;
    end
  end

  assign oDATA   = dat_q;
  assign oX_Cont = x_q;
  assign oY_Cont = y_q;
  assign oDVAL   = vld_q;
endmodule

// File: tb/tb_bayer_quad_grey.sv
// Drives a 1280-wide and an 8-wide instance with the same raw stream and scores both.
module tb_bayer_quad_grey;
  logic           clk = 1'b0;
  logic           rst;
  logic           dval;
  logic [10:0]    xc;
  logic [10:0]    yc;
  img_pkg::pix_t  din;

  logic [11:0] big_dat, sml_dat;
  logic [10:0] big_x, big_y, sml_x, sml_y;
  logic        big_vld, sml_vld;

  always #5 clk = ~clk;

  bayer_quad_grey #(.IMG_WIDTH(1280), .DATA_W(12)) u_big (
    .iCLK(clk), .iRST(rst), .iX_Cont(xc), .iY_Cont(yc), .iDATA(din), .iDVAL(dval),
    .oDATA(big_dat), .oX_Cont(big_x), .oY_Cont(big_y), .oDVAL(big_vld)
  );

  bayer_quad_grey #(.IMG_WIDTH(8), .DATA_W(12)) u_sml (
    .iCLK(clk), .iRST(rst), .iX_Cont(xc), .iY_Cont(yc), .iDATA(din), .iDVAL(dval),
    .oDATA(sml_dat), .oX_Cont(sml_x), .oY_Cont(sml_y), .oDVAL(sml_vld)
  );

  typedef struct {
    int dat;
    int x;
    int y;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   width[2] = '{1280, 8};
  int   he[2];
  int   ho[2];
  int   rdv[2];
  int   lb[int];
  int   last_dat[2];
  int   cyc;
  int   checks;
  int   failures;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: quads assembled from the stored even-row pair, the odd-row
  // even pixel, and the completing pixel; everything keyed by spec rules.
  function automatic void model_beat(input int d, input int x, input int y, input int v);
    int   key;
    int   sel;
    int   sum;
    exp_t e;
    if (x >= width[d]) return;
    key = d * 4096 + x / 2;
    sel = (y % 2) * 2 + (x % 2);
    case (sel)
      0: he[d] = v;
      1: lb[key] = he[d] * 4096 + v;
      2: begin
        ho[d]  = v;
        rdv[d] = lb.exists(key) ? lb[key] : 0;
      end
      default: begin
        sum   = rdv[d] / 4096 + rdv[d] % 4096 + ho[d] + v;
        e.dat = sum / 4;
        e.x   = x / 2;
        e.y   = y / 2;
        e.cyc = cyc + 1;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (big_vld === 1'b1) begin
      if (q0.size() == 0) chk("big_unexpected_dval", int'(big_vld), 0);
      else begin
        e = q0.pop_front();
        chk("big_data", int'(big_dat), e.dat);
        chk("big_x", int'(big_x), e.x);
        chk("big_y", int'(big_y), e.y);
        chk("big_latency_cycle", cyc, e.cyc);
        last_dat[0] = e.dat;
      end
    end
    if (sml_vld === 1'b1) begin
      if (q1.size() == 0) chk("sml_unexpected_dval", int'(sml_vld), 0);
      else begin
        e = q1.pop_front();
        chk("sml_data", int'(sml_dat), e.dat);
        chk("sml_x", int'(sml_x), e.x);
        chk("sml_y", int'(sml_y), e.y);
        chk("sml_latency_cycle", cyc, e.cyc);
        last_dat[1] = e.dat;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dval = 1'b0;
      xc   = 11'($urandom_range(0, 2047));
      yc   = 11'($urandom_range(0, 2047));
      din  = 12'($urandom_range(0, 4095));
    end
  endtask

  task automatic beat(input int x, input int y, input int v, input int gap);
    @(negedge clk);
    rst  = 1'b0;
    dval = 1'b1;
    xc   = 11'(x);
    yc   = 11'(y);
    din  = 12'(v);
    model_beat(0, x, y, v);
    model_beat(1, x, y, v);
    if (gap > 0) idle(gap);
  endtask

  task automatic frame(input int w, input int h, input int y0, input bit rnd,
                       input int val, input int gapmax);
    int v;
    int g;
    for (int y = y0; y < y0 + h; y++) begin
      for (int x = 0; x < w; x++) begin
        v = rnd ? $urandom_range(0, 4095) : val;
        g = (gapmax > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, gapmax) : 0;
        beat(x, y, v, g);
      end
    end
  endtask

  task automatic do_reset(input int x, input int y, input int v);
    chk("big_hold_before_reset", int'(big_dat), last_dat[0]);
    chk("sml_hold_before_reset", int'(sml_dat), last_dat[1]);
    @(negedge clk);
    rst  = 1'b1;
    dval = 1'b1;
    xc   = 11'(x);
    yc   = 11'(y);
    din  = 12'(v);
    he   = '{0, 0};
    ho   = '{0, 0};
    rdv  = '{0, 0};
    @(negedge clk);
    chk("big_rst_data", int'(big_dat), 0);
    chk("big_rst_x", int'(big_x), 0);
    chk("big_rst_y", int'(big_y), 0);
    chk("big_rst_dval", int'(big_vld), 0);
    chk("sml_rst_data", int'(sml_dat), 0);
    chk("sml_rst_dval", int'(sml_vld), 0);
    rst  = 1'b0;
    dval = 1'b0;
    last_dat = '{0, 0};
  endtask

  initial begin
    int a, b, c, d;
    checks = 0;
    failures = 0;
    last_dat = '{0, 0};
    he = '{0, 0};
    ho = '{0, 0};
    rdv = '{0, 0};
    rst = 1'b1;
    dval = 1'b0;
    xc = '0;
    yc = '0;
    din = '0;
    repeat (2) @(negedge clk);
    do_reset(0, 0, 0);

    // Flat field, full rate.
    frame(4, 4, 0, 1'b0, 'h800, 0);
    idle(3);
    // Saturated quad and truncation quad.
    beat(0, 2, 'hFFF, 0); beat(1, 2, 'hFFF, 0); beat(0, 3, 'hFFF, 0); beat(1, 3, 'hFFF, 0);
    beat(0, 2, 1, 0);     beat(1, 2, 1, 0);     beat(0, 3, 1, 0);     beat(1, 3, 0, 0);
    // Long gaps between every beat.
    beat(2, 2, 'h100, 5); beat(3, 2, 'h200, 5); beat(2, 3, 'h300, 5); beat(3, 3, 'h400, 5);
    // Out-of-range beats must be invisible, then a legal quad.
    beat(1280, 2, 'h123, 0); beat(1281, 2, 'h456, 0);
    beat(1280, 3, 'h789, 0); beat(1281, 3, 'hABC, 0);
    frame(4, 2, 4, 1'b1, 0, 2);
    idle(3);

    // Reset between the even-row write and the odd-row beats.
    a = $urandom_range(0, 4095); b = $urandom_range(0, 4095);
    c = $urandom_range(0, 4095); d = $urandom_range(0, 4095);
    beat(4, 6, a, 0); beat(5, 6, b, 0);
    idle(2);
    do_reset(5, 6, 'hABC);
    beat(4, 7, c, 0); beat(5, 7, d, 0);
    idle(3);

    // 8-wide geometry: rows 0..3 exercise column 7 and the address wrap.
    frame(8, 4, 0, 1'b1, 0, 1);
    frame(8, 2, 8, 1'b1, 0, 0);
    idle(3);
    // Full-width random frame with sparse gaps.
    frame(1280, 4, 10, 1'b1, 0, 3);
    idle(6);

    chk("big_pending_quads", q0.size(), 0);
    chk("sml_pending_quads", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bayer_quad_grey.md
# bayer_quad_grey

Bayer-to-greyscale front end of the image processing path. Consumes the raw 12-bit sensor pixel stream with its X/Y counters and averages each 2x2 Bayer quad (R, G1, G2, B) into one 12-bit grey pixel. Emits a half-resolution stream with halved coordinates and a valid strobe, which the convolution stage consumes directly. Internally buffers one even raw row so each quad completes on its odd-row, odd-column pixel.

## Interface
Parameters:
- IMG_WIDTH, 1280: raw pixels per row; must be even, at most 2048.
- DATA_W, 12: pixel width.

Ports:
- iCLK  in  1  single clock.
- iRST  in  1  synchronous reset, active-high.
- iX_Cont  in  11  raw column of iDATA.
- iY_Cont  in  11  raw row of iDATA.
- iDATA  in  DATA_W  raw Bayer pixel.
- iDVAL  in  1  pixel valid; one pixel accepted per cycle while high.
- oDATA  out  DATA_W  grey pixel.
- oX_Cont  out  11  grey column = raw column >> 1.
- oY_Cont  out  11  grey row = raw row >> 1.
- oDVAL  out  1  one-cycle strobe per grey pixel.

## Operation
- A beat is accepted when iDVAL=1 and iX_Cont < IMG_WIDTH. Beats with iX_Cont >= IMG_WIDTH are ignored: no write and no output.
- Row parity is iY_Cont[0]; column parity is iX_Cont[0]. The average is independent of Bayer colour order.
- Even row, even column: latch the pixel in hold_even.
- Even row, odd column: write {hold_even, iDATA} (2*DATA_W bits) to line buffer address iX_Cont>>1.
- Odd row, even column: latch the pixel in hold_odd. Issue a buffer read at iX_Cont>>1. Read data is registered and then held until the next read.
- Odd row, odd column: sum = buf_hi + buf_lo + hold_odd + iDATA. The sum is DATA_W+2 bits and cannot overflow. oDATA = sum[DATA_W+1:2], i.e. truncating divide by 4. oX/oY take the halved counters of this beat, and oDVAL pulses.
- Stale data is used as-is. If an even-row pair was never written, or the odd-row even-column beat was missing, the output uses the last stored values. There is no error flag.
- Gaps in iDVAL of any length are allowed anywhere, and held state persists across them.
- No backpressure exists; downstream must accept every oDVAL.

## Timing
- Latency: oDVAL, oDATA, oX_Cont and oY_Cont are registered and valid 1 cycle after the accepting edge of the odd-row odd-column beat.
- oDVAL is high for exactly one cycle per quad. oDATA and the coordinates hold their values until the next quad.
- Buffer read is issued on the odd-row even-column accept. Data is available at least 1 cycle later, which is always before or on the next accepted beat.
- Back-to-back quads at full rate (iDVAL held high) give oDVAL every 2nd cycle on odd rows and never on even rows.
- Reset values:
  - oDATA=0, oX_Cont=0, oY_Cont=0, oDVAL=0.
  - hold_even, hold_odd and the read register are cleared to 0.
  - Line buffer contents are not cleared.
- An iDVAL beat in the same cycle as iRST is dropped.
- Reset mid-row: the first quad of the following odd row may combine pre-reset buffer data. This is defined behaviour.

## Structure
- Shared package img_pkg holds DATA_W=12, COORD_W=11, and the helper type pix_t = logic [DATA_W-1:0].
- Sub-module pair_line_buffer: simple dual-port RAM of depth IMG_WIDTH/2 and width 2*DATA_W, with 1 write port and 1 registered read port, inferable as block RAM.
- Top level holds the parity decode, the hold registers, the adder and the output registers.

## Test plan
- Flat field, all raw pixels 0x800, 4x4 frame at full rate -> four oDVAL pulses, each with oDATA=0x800, at (0,0), (1,0), (0,1), (1,1), each 1 cycle after its odd/odd beat.
- Single quad R=0xFFF, G1=0xFFF, G2=0xFFF, B=0xFFF -> oDATA=0xFFF (sum 0x3FFC, no overflow). R=1, G1=1, G2=1, B=0 -> oDATA=0 (truncation).
- Quad 0x100, 0x200, 0x300, 0x400 delivered with 5 idle cycles between every beat -> oDATA=0x280, with exactly one oDVAL pulse.
- Beat at iX_Cont=IMG_WIDTH (1280) with iDVAL=1 -> no buffer write and no oDVAL; the next legal quad is unaffected.
- Assert iRST for 1 cycle between the even-row write and the odd-row beats -> outputs read 0 during reset. The odd-row quad still completes using the buffered even-row pair, with hold_odd taken from the new beat.
- IMG_WIDTH=8, raw row 1 column 7 completes a quad -> oX_Cont=3, oY_Cont=0, and the buffer address wraps correctly on the next even row.
